// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//
// Selects one of four internal test patterns for the VGA pixel path. A new
// pattern is only applied at a frame start, so a frame never mixes two
// patterns. Pattern changes come from a manual request pulse (i_next) or from
// the auto-advance frame counter (i_auto_en).
//
// Ports:
//   i_Clk          pixel clock
//   rst            synchronous reset, active-high, overrides all inputs
//   x_pos, y_pos   current pixel position from vga_controller
//   valid_pos      position is inside the active area
//   i_next         one-cycle request to advance at the next frame start
//   i_auto_en      level, enables auto-advance every AUTO_FRAMES frames
//   r_px/g_px/b_px registered 3-bit colour channels (1-cycle latency)
//   o_pattern_idx  pattern currently displayed
//   o_frame_start  registered pulse aligned with pixel (0,0) on r/g/b_px
//   o_pending      a manual request is waiting for the next frame start
//
// Build option:
//   VGA_SEQ_BORDER_EN  when defined, active pixels on the outer edge of the
//                      frame are forced to white regardless of pattern.

module vga_pattern_sequencer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned AUTO_FRAMES = 120,
    parameter int unsigned CHECK_LOG2  = 5
) (
    input  logic                        i_Clk,
    input  logic                        rst,
    input  logic [$clog2(H_ACTIVE)-1:0] x_pos,
    input  logic [$clog2(V_ACTIVE)-1:0] y_pos,
    input  logic                        valid_pos,
    input  logic                        i_next,
    input  logic                        i_auto_en,
    output logic [2:0]                  r_px,
    output logic [2:0]                  g_px,
    output logic [2:0]                  b_px,
    output logic [1:0]                  o_pattern_idx,
    output logic                        o_frame_start,
    output logic                        o_pending
);

    localparam int unsigned XW    = $clog2(H_ACTIVE);
    localparam int unsigned YW    = $clog2(V_ACTIVE);
    localparam int unsigned CW    = $clog2(AUTO_FRAMES);
    localparam int          BAR_W = int'(H_ACTIVE / 8);
    localparam int          ROW_H = int'(V_ACTIVE / 8);

    typedef enum logic [0:0] {StRun, StPending} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      pix_q, pix_d;
    logic            fs_q;
    logic            fs;
    logic            advance;
    logic [2:0]      bar;
    logic [2:0]      row;
    logic            chk;
    logic            col_r, col_g, col_b;

    assign fs = valid_pos && (x_pos == '0) && (y_pos == '0);

    // Next-state: manual request FSM and auto-advance counter. Both sources
    // funnel into a single advance strobe so a coincident hit steps idx once.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        advance = 1'b0;

        if (i_auto_en) begin
            if (fs) begin
                if (cnt_q == CW'(AUTO_FRAMES - 1)) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            // A request on the fs cycle itself waits for the following frame.
            StRun: begin
                if (i_next) begin
                    state_d = StPending;
                end
            end
            // Further requests are absorbed while pending.
            StPending: begin
                if (fs) begin
                    state_d = StRun;
                    advance = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        if (advance) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Bar / row index by constant comparison chain; saturates at 7.
    always_comb begin
        bar = 3'd0;
        row = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x_pos) >= k * BAR_W) begin
                bar = 3'(k);
            end
            if (int'(y_pos) >= k * ROW_H) begin
                row = 3'(k);
            end
        end
    end

    // Colour bar order: black, red, yellow, green, cyan, blue, magenta, white.
    assign col_r = (bar == 3'd1) || (bar == 3'd2) || (bar >= 3'd6);
    assign col_g = ((bar >= 3'd2) && (bar <= 3'd4)) || (bar == 3'd7);
    assign col_b = (bar >= 3'd4);
    assign chk   = x_pos[CHECK_LOG2] ^ y_pos[CHECK_LOG2];

    // Pattern select uses idx_d so pixel (0,0) already shows the new pattern.
    always_comb begin
        pix_d = 9'd0;
        unique case (idx_d)
            2'd0:    pix_d = {{3{col_r}}, {3{col_g}}, {3{col_b}}};
            2'd1:    pix_d = {9{chk}};
            2'd2:    pix_d = {bar, bar, bar};
            default: pix_d = {row, 6'd0};
        endcase
`ifdef VGA_SEQ_BORDER_EN
        if ((x_pos == '0) || (x_pos == XW'(H_ACTIVE - 1)) ||
            (y_pos == '0) || (y_pos == YW'(V_ACTIVE - 1))) begin
            pix_d = 9'h1ff;
        end
`endif
        if (!valid_pos) begin
            pix_d = 9'd0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (rst) begin
            state_q <= StRun;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            pix_q   <= 9'd0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            fs_q    <= fs;
        end
    end

    assign r_px          = pix_q[8:6];
    assign g_px          = pix_q[5:3];
    assign b_px          = pix_q[2:0];
    assign o_pattern_idx = idx_q;
    assign o_frame_start = fs_q;
    assign o_pending     = (state_q == StPending);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer. Positions are driven
// directly (no full-frame scan) so frames are short; a frame is simply the
// span between frame-start cycles. AUTO_FRAMES is reduced to 3.

module tb_vga_pattern_sequencer;

    localparam int AF = 3;

    logic       i_Clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_pos = '0;
    logic [8:0] y_pos = '0;
    logic       valid_pos = 1'b0;
    logic       i_next = 1'b0;
    logic       i_auto_en = 1'b0;
    logic [2:0] r_px, g_px, b_px;
    logic [1:0] o_pattern_idx;
    logic       o_frame_start, o_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_idx = 0;
    int         m_cnt = 0;
    bit         m_pend = 1'b0;
    logic [12:0] exp_v = '0;
    logic [12:0] obs;

    assign obs = {r_px, g_px, b_px, o_pattern_idx, o_frame_start, o_pending};

    vga_pattern_sequencer #(
        .H_ACTIVE    (640),
        .V_ACTIVE    (480),
        .AUTO_FRAMES (AF),
        .CHECK_LOG2  (5)
    ) dut (
        .i_Clk         (i_Clk),
        .rst           (rst),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .valid_pos     (valid_pos),
        .i_next        (i_next),
        .i_auto_en     (i_auto_en),
        .r_px          (r_px),
        .g_px          (g_px),
        .b_px          (b_px),
        .o_pattern_idx (o_pattern_idx),
        .o_frame_start (o_frame_start),
        .o_pending     (o_pending)
    );

    always #5 i_Clk = ~i_Clk;

    // Expected pixel as {r,g,b} from plain division arithmetic.
    function automatic logic [8:0] px(int idx, int x, int y, bit v);
        int bar;
        int row;
        logic [8:0] c;
        bar = (x / 80 > 7) ? 7 : x / 80;
        row = (y / 60 > 7) ? 7 : y / 60;
        case (idx)
            0: begin
                case (bar)
                    0:       c = 9'o000;
                    1:       c = 9'o700;
                    2:       c = 9'o770;
                    3:       c = 9'o070;
                    4:       c = 9'o077;
                    5:       c = 9'o007;
                    6:       c = 9'o707;
                    default: c = 9'o777;
                endcase
            end
            1:       c = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 9'o777 : 9'o000;
            2:       c = 9'(bar * 73);
            default: c = 9'(row * 64);
        endcase
`ifdef VGA_SEQ_BORDER_EN
        if (x == 0 || x == 639 || y == 0 || y == 479) c = 9'o777;
`endif
        if (!v) c = 9'o000;
        return c;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic cyc(input int x, input int y, input bit v, input bit nxt,
                       input bit a, input bit r);
        bit fsc;
        bit adv;
        x_pos     = 10'(x);
        y_pos     = 9'(y);
        valid_pos = v;
        i_next    = nxt;
        i_auto_en = a;
        rst       = r;
        @(posedge i_Clk);
        fsc = v && x == 0 && y == 0;
        if (r) begin
            m_idx  = 0;
            m_cnt  = 0;
            m_pend = 1'b0;
            exp_v  = '0;
        end else begin
            adv = 1'b0;
            if (!a) m_cnt = 0;
            else if (fsc) begin
                if (m_cnt == AF - 1) begin
                    adv   = 1'b1;
                    m_cnt = 0;
                end else m_cnt++;
            end
            if (m_pend) begin
                if (fsc) begin
                    adv    = 1'b1;
                    m_pend = 1'b0;
                end
            end else if (nxt) m_pend = 1'b1;
            if (adv) m_idx = (m_idx + 1) % 4;
            exp_v = {px(m_idx, x, y, v), 2'(m_idx), fsc, m_pend};
        end
        #1;
        i_next = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        cyc($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, 13'd0);
        end
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_colour_bars();
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_frame_start !== 1'b1 || {r_px, g_px, b_px} !== 9'o000) begin
            errors++;
            $display("FAIL bars_fs: got fs=%b px=%o want fs=1 px=000",
                     o_frame_start, {r_px, g_px, b_px});
        end
        cyc(100, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o700) begin
            errors++;
            $display("FAIL bars_red: got %o want 700", {r_px, g_px, b_px});
        end
        cyc(600, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o777) begin
            errors++;
            $display("FAIL bars_white: got %o want 777", {r_px, g_px, b_px});
        end
        cyc(600, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o000 || o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL bars_blank: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_manual_next();
        cyc(200, 100, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_pending !== 1'b1 || o_pattern_idx !== 2'd0) begin
            errors++;
            $display("FAIL next_pending: got pend=%b idx=%0d want pend=1 idx=0",
                     o_pending, o_pattern_idx);
        end
        cyc(300, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL next_hold: got %h want %h", obs, exp_v);
        end
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_pattern_idx, o_frame_start, o_pending} !== 4'b0110 ||
            {r_px, g_px, b_px} !== 9'o000) begin
            errors++;
            $display("FAIL next_fs: got %h want idx=1 fs=1 pend=0 px=000", obs);
        end
        cyc(32, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o777) begin
            errors++;
            $display("FAIL next_checker: got %o want 777", {r_px, g_px, b_px});
        end
    endtask

    task automatic test_multi_next();
        cyc(10, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(400, 50, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(639, 479, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_pattern_idx !== 2'd2 || o_pending !== 1'b0) begin
            errors++;
            $display("FAIL multi_next: got idx=%0d pend=%b want idx=2 pend=0",
                     o_pattern_idx, o_pending);
        end
        for (int f = 0; f < 4; f++) begin
            cyc(50, 50, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (o_pattern_idx !== 2'((3 + f) % 4) || obs !== exp_v) begin
                errors++;
                $display("FAIL wrap_frame%0d: got %h want %h", f, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Request on the fs cycle itself: not applied on this fs.
        cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_pattern_idx !== 2'd2 || o_pending !== 1'b1) begin
            errors++;
            $display("FAIL fs_req_hold: got idx=%0d pend=%b want idx=2 pend=1",
                     o_pattern_idx, o_pending);
        end
        cyc(5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_pattern_idx !== 2'd3 || o_pending !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("FAIL fs_req_apply: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_auto();
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 1; f <= 6; f++) begin
            cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (o_pattern_idx !== 2'(f / 3) || obs !== exp_v) begin
                errors++;
                $display("FAIL auto_fs%0d: got idx=%0d want %0d", f, o_pattern_idx, f / 3);
            end
            cyc(70, 20, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        // Manual request coinciding with the auto wrap advances once.
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(90, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_pattern_idx !== 2'd1 || o_pending !== 1'b0) begin
            errors++;
            $display("FAIL auto_and_next: got idx=%0d pend=%b want idx=1 pend=0",
                     o_pattern_idx, o_pending);
        end
        for (int f = 4; f <= 6; f++) begin
            cyc(2, 2, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (o_pattern_idx !== 2'd2 || obs !== exp_v) begin
            errors++;
            $display("FAIL auto_restart: got idx=%0d want 2", o_pattern_idx);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            cyc(50, 50, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(320, 240, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_pattern_idx !== 2'd2 || o_pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got idx=%0d pend=%b want idx=2 pend=1",
                     o_pattern_idx, o_pending);
        end
        cyc(320, 240, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0", obs);
        end
        cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(100, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o700 || o_pattern_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_after_red: got %o idx=%0d want 700 idx=0",
                     {r_px, g_px, b_px}, o_pattern_idx);
        end
        cyc(400, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o007) begin
            errors++;
            $display("FAIL mid_after_blue: got %o want 007", {r_px, g_px, b_px});
        end
    endtask

    task automatic test_border();
        logic [8:0] want_edge;
`ifdef VGA_SEQ_BORDER_EN
        want_edge = 9'o777;
`else
        want_edge = 9'o000;
`endif
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            cyc(50, 50, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== want_edge || o_pattern_idx !== 2'd3) begin
            errors++;
            $display("FAIL border_left: got %o idx=%0d want %o idx=3",
                     {r_px, g_px, b_px}, o_pattern_idx, want_edge);
        end
        cyc(639, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== want_edge) begin
            errors++;
            $display("FAIL border_right: got %o want %o", {r_px, g_px, b_px}, want_edge);
        end
        cyc(1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_px, g_px, b_px} !== 9'o000) begin
            errors++;
            $display("FAIL border_inner: got %o want 000", {r_px, g_px, b_px});
        end
    endtask

    task automatic test_random();
        int  x, y;
        bit  v, n, a, r;
        int  bad = 0;
        a = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                x = 0;
                y = 0;
                v = 1'b1;
            end else begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
                v = ($urandom_range(0, 9) != 0);
            end
            n = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 99) == 0) a = ~a;
            r = ($urandom_range(0, 299) == 0);
            cyc(x, y, v, n, a, r);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                bad++;
                if (bad <= 10) begin
                    $display("FAIL random[%0d] x=%0d y=%0d v=%b: got %h want %h",
                             i, x, y, v, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_colour_bars();
        test_manual_next();
        test_multi_next();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        test_border();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Pixel-source controller for the VGA timing path. It consumes x_pos, y_pos and valid_pos from vga_controller, owns four internal test-pattern generators, and decides which one drives the r/g/b pixel value. Pattern changes happen only on frame boundaries, so no frame ever contains two patterns. Changes come from a manual request pulse or from an auto-advance frame counter.

Parameters:
H_ACTIVE, 640, active pixels per line; x_pos width = $clog2(H_ACTIVE) = 10
V_ACTIVE, 480, active lines per frame; y_pos width = $clog2(V_ACTIVE) = 9
AUTO_FRAMES, 120, frames per pattern when auto-advance is enabled; must be >= 2
CHECK_LOG2, 5, checkerboard square edge = 2**CHECK_LOG2 pixels

Ports:
i_Clk  input  1  pixel clock, shared with vga_controller
rst  input  1  synchronous reset, active-high
x_pos  input  10  current pixel column from vga_controller
y_pos  input  9  current pixel row from vga_controller
valid_pos  input  1  x_pos/y_pos is inside the active area
i_next  input  1  single-cycle request: advance to next pattern at next frame start
i_auto_en  input  1  level; 1 enables auto-advance every AUTO_FRAMES frames
r_px  output  3  red pixel value, registered
g_px  output  3  green pixel value, registered
b_px  output  3  blue pixel value, registered
o_pattern_idx  output  2  pattern currently displayed
o_frame_start  output  1  one-cycle pulse, registered, aligned with pixel (0,0) on r/g/b_px
o_pending  output  1  a manual request is latched and waiting for a frame start

Behaviour:
- Reset values (one clock after rst is sampled high): r/g/b_px = 0, o_pattern_idx = 0, o_frame_start = 0, o_pending = 0, frame counter = 0, FSM = RUN. rst overrides all other inputs.
- Reset mid-frame: outputs go to 0 on the next edge. Display restarts with pattern 0 at the next frame start.
- Frame-start cycle (fs): valid_pos = 1 and x_pos = 0 and y_pos = 0.
- FSM has two states:
  - RUN. i_next = 1 -> PENDING; o_pending = 1 from the next cycle.
  - PENDING. On fs: idx <= idx+1 (wraps 3 -> 0), -> RUN, o_pending <= 0.
  - i_next while in PENDING is absorbed; multiple requests within one frame advance by exactly one.
  - i_next on the fs cycle itself while in RUN latches as pending; it takes effect at the following frame start, not the current one.
- Auto-advance:
  - Frame counter increments on each fs while i_auto_en = 1.
  - When the counter = AUTO_FRAMES-1 on an fs: idx advances, counter <= 0.
  - i_auto_en = 0 holds the counter at 0.
  - Auto-advance and a pending manual request on the same fs: idx advances by exactly 1, the counter clears, and the pending flag clears.
- Pattern select for the fs cycle uses the updated index (idx_next). Pixel (0,0) is already drawn with the new pattern.
- Pixel latency is 1 cycle: inputs at edge n -> r/g/b_px at edge n+1. o_frame_start uses the same 1-cycle delay.
- When valid_pos = 0, the registered r/g/b_px = 0.
- Patterns (bar k = 0..7, by comparison chain against k*80, no divider):
  - 0 colour bars: bar k = x_pos/80; colours black, red, yellow, green, cyan, blue, magenta, white. Each channel is 3'b111 or 3'b000.
  - 1 checkerboard: white (7,7,7) if x_pos[CHECK_LOG2] ^ y_pos[CHECK_LOG2], else black.
  - 2 grey ramp: r = g = b = x_pos/80 (0..7).
  - 3 red vertical ramp: r = y_pos/60 (0..7), g = b = 0.
- x_pos/y_pos outside the active range with valid_pos = 1 never occurs. If it does, bar index saturates at 7.

Optional Feature:
VGA_SEQ_BORDER_EN
- Defined: when valid_pos = 1 and (x_pos = 0 or x_pos = H_ACTIVE-1 or y_pos = 0 or y_pos = V_ACTIVE-1), the pixel is forced to white (7,7,7), overriding every pattern. Latency is unchanged.
- Undefined: no border logic is generated; edge pixels show the pattern value.

Test Plan:
- Reset then run one frame at idx 0 -> x = 100 gives (7,0,0) one cycle later; x = 600 gives (7,7,7); valid_pos = 0 gives (0,0,0).
- i_next pulse at (x = 200, y = 100) -> o_pending = 1 the next cycle; o_pattern_idx stays 0 until fs; on fs idx = 1, o_frame_start = 1 and pixel (0,0) = black; (32,0) = white.
- Three i_next pulses within one frame -> idx advances 1 -> 2 only. Four separate frames of requests from idx 0 -> idx 0 (wrap).
- i_auto_en = 1 with AUTO_FRAMES = 3, no i_next -> idx changes at the 3rd and 6th fs. Add i_next during frame 2 -> single advance at the 3rd fs, counter restarts.
- Assert rst at (x = 320, y = 240) while idx = 2 and pending -> next cycle all outputs 0, o_pending = 0. Next frame shows pattern 0 (grey at x = 400 absent; red bar at x = 100 = (7,0,0)).
- With VGA_SEQ_BORDER_EN, idx = 3 -> (0,10) and (639,10) are (7,7,7); (1,10) is (0,0,0). Without the macro, (0,10) is (0,0,0).
